// File: rtl/block_dispatcher.sv
// Kernel block dispatcher: splits a launch into THREADS_PER_CORE-sized blocks and feeds idle cores one per cycle.
// Optional macro DISPATCH_PERF_EN adds a saturating stall_cycles counter output.
module block_dispatcher #(
  parameter int NUM_CORES        = 2,
  parameter int THREADS_PER_CORE = 2,
  parameter int TC_WIDTH         = 8
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              start,
  input  logic [TC_WIDTH-1:0]                               thread_count,
  output logic [NUM_CORES-1:0]                              core_start,
  output logic [NUM_CORES*TC_WIDTH-1:0]                     core_block_id,
  output logic [NUM_CORES*$clog2(THREADS_PER_CORE+1)-1:0]   core_thread_count,
  input  logic [NUM_CORES-1:0]                              core_done,
  output logic                                              busy,
  output logic                                              done,
  output logic [TC_WIDTH-1:0]                               blocks_dispatched,
  output logic [TC_WIDTH-1:0]                               blocks_completed
`ifdef DISPATCH_PERF_EN
  ,
  output logic [31:0]                                       stall_cycles
`endif
);

  localparam int CNT_W = $clog2(THREADS_PER_CORE + 1);
  localparam logic [TC_WIDTH-1:0] TPC_TC  = TC_WIDTH'(THREADS_PER_CORE);
  localparam logic [CNT_W-1:0]    TPC_CNT = CNT_W'(THREADS_PER_CORE);

  typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_WAIT, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [TC_WIDTH-1:0]   total_blocks, total_nxt, tc_quo, tc_rem;
  logic [CNT_W-1:0]      last_cnt, last_cnt_nxt, issue_cnt;
  logic [NUM_CORES-1:0]  core_busy, valid_done, grant;
  logic [TC_WIDTH-1:0]   id_q  [NUM_CORES];
  logic [CNT_W-1:0]      cnt_q [NUM_CORES];
  logic                  accept, pending, dispatch, found;
  logic [TC_WIDTH-1:0]   dispatched_nxt, completed_nxt;

  function automatic logic [TC_WIDTH-1:0] popcount(input logic [NUM_CORES-1:0] v);
    logic [TC_WIDTH-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_CORES; i++) n = n + TC_WIDTH'(v[i]);
    return n;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  // Launch decode, dispatch arbitration and FSM next state
  always_comb begin
    accept       = start && (state == S_IDLE || state == S_DONE);
    tc_quo       = thread_count / TPC_TC;
    tc_rem       = thread_count % TPC_TC;
    total_nxt    = tc_quo + TC_WIDTH'(tc_rem != '0);
    last_cnt_nxt = (tc_rem == '0) ? TPC_CNT : CNT_W'(tc_rem);

    pending = (state == S_DISPATCH) && (blocks_dispatched < total_blocks);
    grant   = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!found && !core_busy[i]) begin
        grant[i] = pending;
        found    = 1'b1;
      end
    end
    dispatch  = |grant;
    issue_cnt = (blocks_dispatched == total_blocks - TC_WIDTH'(1)) ? last_cnt : TPC_CNT;

    // Completions from cores that hold no block are stray and dropped
    valid_done     = core_done & core_busy;
    completed_nxt  = blocks_completed + popcount(valid_done);
    dispatched_nxt = blocks_dispatched + TC_WIDTH'(dispatch);

    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = (thread_count == '0) ? S_DONE : S_DISPATCH;
      S_DISPATCH:     if (dispatched_nxt == total_blocks) state_nxt = S_WAIT;
      S_WAIT:         if (completed_nxt == total_blocks) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Outputs: a fresh assignment is visible in the same cycle as its core_start pulse
  always_comb begin
    core_start        = grant;
    core_block_id     = '0;
    core_thread_count = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      core_block_id[i*TC_WIDTH +: TC_WIDTH] = grant[i] ? blocks_dispatched : id_q[i];
      core_thread_count[i*CNT_W +: CNT_W]   = grant[i] ? issue_cnt : cnt_q[i];
    end
    busy = (state == S_DISPATCH) || (state == S_WAIT);
    done = (state == S_DONE);
  end

  // Control and held assignment registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= S_IDLE;
      blocks_dispatched <= '0;
      blocks_completed  <= '0;
      core_busy         <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        id_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (accept) begin
        blocks_dispatched <= '0;
        blocks_completed  <= '0;
      end else begin
        blocks_dispatched <= dispatched_nxt;
        blocks_completed  <= completed_nxt;
      end
      core_busy <= (core_busy & ~valid_done) | grant;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (grant[i]) begin
          id_q[i]  <= blocks_dispatched;
          cnt_q[i] <= issue_cnt;
        end
      end
    end
  end

  // Launch geometry, only consulted after an accepted start
  always_ff @(posedge clk) begin
    if (accept) begin
      total_blocks <= total_nxt;
      last_cnt     <= last_cnt_nxt;
    end
  end

`ifdef DISPATCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) stall_cycles <= '0;
    else if (accept) stall_cycles <= '0;
    else if (pending && (&core_busy)) stall_cycles <= sat_inc(stall_cycles);
  end
`endif

endmodule

// File: tb/tb_block_dispatcher.sv
// Self-checking bench for block_dispatcher: directed launches against a rule-level model plus literal checks.
module tb_block_dispatcher;
  localparam int NC  = 2;
  localparam int TPC = 2;
  localparam int TCW = 8;
  localparam int CW  = $clog2(TPC + 1);

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [TCW-1:0]    thread_count = '0;
  logic [NC-1:0]     core_start;
  logic [NC*TCW-1:0] core_block_id;
  logic [NC*CW-1:0]  core_thread_count;
  logic [NC-1:0]     core_done;
  logic [NC-1:0]     resp_done = '0;
  logic [NC-1:0]     man_done = '0;
  logic              busy, done;
  logic [TCW-1:0]    blocks_dispatched, blocks_completed;
`ifdef DISPATCH_PERF_EN
  logic [31:0]       stall_cycles;
`endif

  assign core_done = resp_done | man_done;

  block_dispatcher #(.NUM_CORES(NC), .THREADS_PER_CORE(TPC), .TC_WIDTH(TCW)) dut (
    .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
    .core_start(core_start), .core_block_id(core_block_id),
    .core_thread_count(core_thread_count), .core_done(core_done),
    .busy(busy), .done(done),
    .blocks_dispatched(blocks_dispatched), .blocks_completed(blocks_completed)
`ifdef DISPATCH_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Rule-level model of one launch
  int m_active = 0, m_done = 0, m_tc = 0, m_total = 0, m_disp = 0, m_comp = 0, m_stall = 0;
  int m_busy[NC], m_id[NC], m_cnt[NC];
  int done_at[NC], lat[NC];
  int cyc = 0;
  bit cmp_en = 1'b0;

  function automatic int m_grant();
    if (m_active != 0 && m_disp < m_total)
      for (int i = 0; i < NC; i++) if (m_busy[i] == 0) return i;
    return -1;
  endfunction

  function automatic int blk_threads(input int b);
    return (b == m_total - 1) ? (m_tc - b * TPC) : TPC;
  endfunction

  always @(posedge clk) begin
    int g;
    int nd;
    if (!reset) begin
      m_active = 0; m_done = 0; m_disp = 0; m_comp = 0; m_stall = 0;
      for (int i = 0; i < NC; i++) begin
        m_busy[i] = 0; m_id[i] = 0; m_cnt[i] = 0; done_at[i] = -1;
      end
    end else if (m_active != 0) begin
      g  = m_grant();
      nd = 0;
      for (int i = 0; i < NC; i++)
        if (core_done[i] && m_busy[i] != 0) begin m_busy[i] = 0; nd++; end
      if (g < 0 && m_disp < m_total) m_stall++;
      if (g >= 0) begin
        m_busy[g] = 1; m_id[g] = m_disp; m_cnt[g] = blk_threads(m_disp);
        m_disp++;
        done_at[g] = cyc + lat[g];
      end
      m_comp += nd;
      if (m_comp == m_total) begin m_active = 0; m_done = 1; end
    end else if (start) begin
      m_tc = int'(thread_count);
      m_total = (m_tc + TPC - 1) / TPC;
      m_disp = 0; m_comp = 0; m_stall = 0;
      m_done   = (m_tc == 0) ? 1 : 0;
      m_active = (m_tc != 0) ? 1 : 0;
    end
    cyc++;
    #1;
    for (int i = 0; i < NC; i++) resp_done[i] = (done_at[i] == cyc);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      int g;
      g = m_grant();
      check("core_start", core_start, (g < 0) ? 0 : (1 << g));
      for (int i = 0; i < NC; i++) begin
        check("core_block_id", core_block_id[i*TCW +: TCW], (g == i) ? m_disp : m_id[i]);
        check("core_thread_count", core_thread_count[i*CW +: CW],
              (g == i) ? blk_threads(m_disp) : m_cnt[i]);
      end
      check("busy", busy, m_active);
      check("done", done, m_done);
      check("blocks_dispatched", blocks_dispatched, m_disp);
      check("blocks_completed", blocks_completed, m_comp);
`ifdef DISPATCH_PERF_EN
      check("stall_cycles", stall_cycles, m_stall);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int tc);
    start = 1'b1;
    thread_count = TCW'(tc);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    while (!done && n < max) begin
      tick();
      n++;
    end
    if (!done) check("wait_done_timeout", 0, 1);
  endtask

  initial begin
    int n;
    lat[0] = 3; lat[1] = 3;
    reset = 1'b0;
    tick(); tick();
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst_core_start", core_start, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    tick();
    reset = 1'b1;

    // Empty kernel completes without dispatching
    tick();
    launch(0);
    @(negedge clk);
    check("t0_done", done, 1);
    check("t0_busy", busy, 0);
    check("t0_core_start", core_start, 0);

    // Four threads: two blocks on consecutive cycles, relaunch from DONE
    tick();
    launch(4);
    @(negedge clk);
    check("t1_done_falls", done, 0);
    check("t1_start0", core_start, 1);
    check("t1_id0", core_block_id[TCW-1:0], 0);
    check("t1_cnt0", core_thread_count[CW-1:0], 2);
    tick();
    @(negedge clk);
    check("t1_start1", core_start, 2);
    check("t1_id1", core_block_id[2*TCW-1:TCW], 1);
    check("t1_cnt1", core_thread_count[2*CW-1:CW], 2);
    wait_done(20, n);
    check("t1_latency", n, 4);
    check("t1_completed", blocks_completed, 2);

    // Five threads: partial third block goes to the first freed core
    tick();
    launch(5);
    wait_done(30, n);
    check("t2_latency", n, 8);
    check("t2_dispatched", blocks_dispatched, 3);
    check("t2_completed", blocks_completed, 3);
    check("t2_last_id", core_block_id[TCW-1:0], 2);
    check("t2_last_cnt", core_thread_count[CW-1:0], 1);

    // Eight threads, both cores retire in the same cycle
    lat[0] = 4; lat[1] = 3;
    tick();
    launch(8);
    repeat (4) tick();
    @(negedge clk);
    check("t3_comp_before", blocks_completed, 0);
    tick();
    @(negedge clk);
    check("t3_comp_after", blocks_completed, 2);
    check("t3_start2", core_start, 1);
    check("t3_id2", core_block_id[TCW-1:0], 2);
    tick();
    @(negedge clk);
    check("t3_start3", core_start, 2);
    check("t3_id3", core_block_id[2*TCW-1:TCW], 3);
    wait_done(30, n);
    check("t3_completed", blocks_completed, 4);

    // Reset while waiting for the last block
    lat[0] = 3; lat[1] = 3;
    tick();
    launch(6);
    repeat (5) tick();
    @(negedge clk);
    check("t4_busy_wait", busy, 1);
    check("t4_disp_wait", blocks_dispatched, 3);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("t4_rst_start", core_start, 0);
    check("t4_rst_ids", core_block_id, 0);
    check("t4_rst_cnts", core_thread_count, 0);
    check("t4_rst_busy", busy, 0);
    check("t4_rst_done", done, 0);
    check("t4_rst_disp", blocks_dispatched, 0);
    check("t4_rst_comp", blocks_completed, 0);
    tick();
    man_done = 2'b11;
    tick();
    man_done = 2'b00;
    @(negedge clk);
    check("t4_spurious_comp", blocks_completed, 0);
    tick();
    launch(2);
    wait_done(10, n);
    check("t4_relaunch_latency", n, 4);
    check("t4_relaunch_comp", blocks_completed, 1);

    // Start while busy is ignored; long core occupancy causes stalls
    lat[0] = 4; lat[1] = 4;
    tick();
    launch(6);
    tick();
    start = 1'b1;
    thread_count = 8'd200;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("t5_disp_mid", blocks_dispatched, 2);
    check("t5_busy_mid", busy, 1);
    wait_done(30, n);
    check("t5_disp", blocks_dispatched, 3);
    check("t5_comp", blocks_completed, 3);
`ifdef DISPATCH_PERF_EN
    check("t5_stall", stall_cycles, 3);
`endif

    tick();
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
